// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 FIFO-mode port.
package ft245_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STROBE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
        S_TURN
    } state_e;

    typedef enum logic {
        GRANT_RX,
        GRANT_TX
    } grant_e;

endpackage

// File: rtl/ft245_port_sync_fifo.sv
// Single-clock FIFO; full/empty told apart by an extra pointer bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ft245_port.sv
// FT245 FIFO-mode bridge between byte streams and the chip pads.
// Define FT245_STATS_EN to build the 16-bit rx/tx byte counters.
module ft245_port
    import ft245_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 16,
    parameter int STROBE_CYCLES = 4,
    parameter int TURN_CYCLES   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_txe_n,
    input  logic              pad_rxf_n,
    input  logic [BYTE_W-1:0] pad_data_i,
    output logic [BYTE_W-1:0] pad_data_o,
    output logic              pad_data_oe,
    output logic              pad_rd,
    output logic              pad_wr,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [15:0]       rx_count,
    output logic [15:0]       tx_count
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STROBE_CYCLES < 1) begin : g_bad_strobe
        $error("STROBE_CYCLES must be at least 1");
    end
    // Flags must resynchronise before IDLE looks at them again.
    if (TURN_CYCLES < SYNC_STAGES + 1) begin : g_bad_turn
        $error("TURN_CYCLES must be at least SYNC_STAGES+1");
    end

    localparam int CNT_MAX = (STROBE_CYCLES > TURN_CYCLES) ?
                             STROBE_CYCLES : TURN_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] TRN_LAST = CW'(TURN_CYCLES - 1);

    logic [SYNC_STAGES-1:0] txe_sync_q, txe_sync_d;
    logic [SYNC_STAGES-1:0] rxf_sync_q, rxf_sync_d;
    logic                   txe_n_s, rxf_n_s;

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              oe_q, oe_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;

    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [BYTE_W-1:0] tx_head;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic              rx_req, tx_req;

    assign txe_sync_d = {txe_sync_q[SYNC_STAGES-2:0], pad_txe_n};
    assign rxf_sync_d = {rxf_sync_q[SYNC_STAGES-2:0], pad_rxf_n};
    assign txe_n_s    = txe_sync_q[SYNC_STAGES-1];
    assign rxf_n_s    = rxf_sync_q[SYNC_STAGES-1];

    assign ready_d  = 1'b1;
    assign tx_ready = ready_q && !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    assign rx_req = !rxf_n_s && !rx_full;
    assign tx_req = !txe_n_s && !tx_empty;

    assign pad_rd      = rd_q;
    assign pad_wr      = wr_q;
    assign pad_data_oe = oe_q;
    assign pad_data_o  = data_q;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (pad_data_i),
        .pop       (rx_pop),
        .head      (rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        oe_d    = oe_q;
        data_d  = data_q;
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // On a tie, serve the direction that lost last time.
                if (rx_req && (!tx_req || grant_q == GRANT_TX)) begin
                    state_d = S_RD_STROBE;
                    grant_d = GRANT_RX;
                    rd_d    = 1'b1;
                end else if (tx_req) begin
                    state_d = S_WR_SETUP;
                    grant_d = GRANT_TX;
                    oe_d    = 1'b1;
                    data_d  = tx_head;
                end
            end
            S_RD_STROBE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == STB_LAST) begin
                    rx_push = 1'b1;
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_TURN;
                end
            end
            S_WR_SETUP: begin
                wr_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_WR_STROBE;
            end
            S_WR_STROBE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == STB_LAST) begin
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WR_HOLD;
                end
            end
            S_WR_HOLD: begin
                tx_pop  = 1'b1;
                oe_d    = 1'b0;
                data_d  = '0;
                state_d = S_TURN;
            end
            S_TURN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TRN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txe_sync_q <= '1;
            rxf_sync_q <= '1;
            state_q    <= S_IDLE;
            grant_q    <= GRANT_TX;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            oe_q       <= 1'b0;
            data_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            txe_sync_q <= txe_sync_d;
            rxf_sync_q <= rxf_sync_d;
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
        end
    end

`ifdef FT245_STATS_EN
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;

    assign rx_cnt_d = rx_cnt_q + {15'd0, rx_push};
    assign tx_cnt_d = tx_cnt_q + {15'd0, tx_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    assign rx_count = rx_cnt_q;
    assign tx_count = tx_cnt_q;
`else
    assign rx_count = '0;
    assign tx_count = '0;
`endif

endmodule
